// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: PC, imem request/grant/response, instruction FIFO
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_gnt,
  input  logic        i_imem_rvalid,
  input  logic [31:0] i_imem_rdata,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic        o_instr_valid,
  output logic [31:0] o_instr,
  output logic [31:0] o_pc,
  input  logic        i_id_ready
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DISCARD} state_t;

  state_t        state, state_nxt;
  logic [31:0]   pc;
  logic [31:0]   instr_mem [DEPTH];
  logic [31:0]   pc_mem    [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count, count_after_pop, count_nxt;
  logic          push, pop, room_now, room_after_push;

  // A redirect cancels both the pop and the push of the same cycle.
  assign pop  = o_instr_valid && i_id_ready && !i_redirect;
  assign push = (state == WAIT) && i_imem_rvalid && !i_redirect;

  always_comb begin
    count_after_pop = pop ? (count - CW'(1)) : count;
    count_nxt       = count_after_pop + (push ? CW'(1) : CW'(0));
    room_now        = (count_after_pop < DEPTH_C);
    room_after_push = ((count_after_pop + CW'(1)) < DEPTH_C);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (room_now) state_nxt = REQ;
      REQ:     if (i_imem_gnt) state_nxt = WAIT;
      WAIT:    if (i_imem_rvalid) state_nxt = room_after_push ? REQ : IDLE;
      DISCARD: if (i_imem_rvalid) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    // An accepted but unanswered fetch must still have its response swallowed.
    if (i_redirect) begin
      case (state)
        REQ:     state_nxt = i_imem_gnt ? DISCARD : IDLE;
        WAIT:    state_nxt = i_imem_rvalid ? IDLE : DISCARD;
        IDLE:    state_nxt = IDLE;
        DISCARD: state_nxt = i_imem_rvalid ? IDLE : DISCARD;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    o_imem_req  = (state == REQ);
    o_imem_addr = pc;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pc     <= RESET_PC;
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else if (i_redirect) begin
      pc     <= i_redirect_pc & 32'hFFFF_FFFC;
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (push) begin
        pc     <= pc + 32'd4;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count_nxt;
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) begin
      instr_mem[wr_ptr] <= i_imem_rdata;
      pc_mem[wr_ptr]    <= pc;
    end
  end

  // Head outputs are muxed only from registered state.
  always_comb begin
    o_instr_valid = (count != '0);
    o_instr       = o_instr_valid ? instr_mem[rd_ptr] : NOP;
    o_pc          = o_instr_valid ? pc_mem[rd_ptr] : pc;
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
module tb_fetch_unit;

  localparam logic [31:0] K   = 32'hA5A5_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req, imem_gnt, imem_rvalid, redirect, instr_valid, id_ready;
  logic [31:0] imem_addr, imem_rdata, redirect_pc, instr, pc;
  logic        w_req, w_rvalid, w_valid;
  logic [31:0] w_addr, w_rdata, w_instr, w_pc;
  logic        auto_rsp;
  int          n_tests = 0;
  int          n_fail  = 0;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .o_imem_req(imem_req), .o_imem_addr(imem_addr), .i_imem_gnt(imem_gnt),
    .i_imem_rvalid(imem_rvalid), .i_imem_rdata(imem_rdata),
    .i_redirect(redirect), .i_redirect_pc(redirect_pc),
    .o_instr_valid(instr_valid), .o_instr(instr), .o_pc(pc), .i_id_ready(id_ready)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .DEPTH(2)) dut_w (
    .i_clk(clk), .i_rst_n(rst_n),
    .o_imem_req(w_req), .o_imem_addr(w_addr), .i_imem_gnt(1'b1),
    .i_imem_rvalid(w_rvalid), .i_imem_rdata(w_rdata),
    .i_redirect(1'b0), .i_redirect_pc(32'h0),
    .o_instr_valid(w_valid), .o_instr(w_instr), .o_pc(w_pc), .i_id_ready(1'b1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock; zero-wait memory answers the cycle after a grant with addr ^ K.
  task automatic tick();
    logic        hs, hs_w;
    logic [31:0] ha, ha_w;
    hs   = imem_req & imem_gnt;
    ha   = imem_addr;
    hs_w = w_req;
    ha_w = w_addr;
    @(posedge clk);
    #1;
    if (auto_rsp) begin
      imem_rvalid = hs;
      imem_rdata  = ha ^ K;
    end
    w_rvalid = hs_w;
    w_rdata  = ha_w ^ K;
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    imem_gnt    = 1'b1;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    id_ready    = 1'b1;
    auto_rsp    = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    w_rvalid = 1'b0;
    w_rdata  = 32'h0;
    do_reset();

    // reset values, streaming at one instruction per two cycles, and wrap instance
    check("rst_req", imem_req, 0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_valid", instr_valid, 0);
    check("rst_instr", instr, NOP);
    check("rst_pc", pc, 32'h0);
    check("w_rst_addr", w_addr, 32'hFFFF_FFFC);
    tick();
    check("first_req", imem_req, 1);
    check("first_addr", imem_addr, 32'h0);
    check("w_first_addr", w_addr, 32'hFFFF_FFFC);
    tick();
    for (int k = 0; k < 4; k++) begin
      tick();
      check("s_valid", instr_valid, 1);
      check("s_pc", pc, 32'(4 * k));
      check("s_instr", instr, 32'(4 * k) ^ K);
      if (k == 0) begin
        check("w_wrap_addr", w_addr, 32'h0);
        check("w_wrap_req", w_req, 1);
        check("w_head_pc", w_pc, 32'hFFFF_FFFC);
        check("w_head_instr", w_instr, 32'hFFFF_FFFC ^ K);
        check("w_valid", w_valid, 1);
      end
      tick();
      check("s_gap", instr_valid, 0);
    end

    // decode stalled: FIFO fills, fetching stops, then drains in order
    do_reset();
    id_ready = 1'b0;
    repeat (5) tick();
    check("full_req", imem_req, 0);
    check("full_addr", imem_addr, 32'h8);
    check("full_head", pc, 32'h0);
    tick();
    tick();
    check("full_req_hold", imem_req, 0);
    check("full_head_instr", instr, 32'h0 ^ K);
    id_ready = 1'b1;
    tick();
    check("drain1_pc", pc, 32'h4);
    check("drain1_instr", instr, 32'h4 ^ K);
    check("drain_req", imem_req, 1);
    check("drain_addr", imem_addr, 32'h8);
    tick();
    check("drain_empty", instr_valid, 0);

    // redirect in WAIT with rvalid in the same cycle
    do_reset();
    tick();
    tick();
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0102;
    tick();
    redirect = 1'b0;
    check("rw_valid", instr_valid, 0);
    check("rw_instr", instr, NOP);
    check("rw_addr", imem_addr, 32'h100);
    tick();
    check("rw_req", imem_req, 1);
    check("rw_req_addr", imem_addr, 32'h100);
    tick();
    tick();
    check("rw_head_valid", instr_valid, 1);
    check("rw_head_pc", pc, 32'h100);
    check("rw_head_instr", instr, 32'h100 ^ K);

    // redirect in REQ with gnt in the same cycle: response must be discarded
    do_reset();
    tick();
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0200;
    tick();
    redirect = 1'b0;
    check("rq_req", imem_req, 0);
    check("rq_valid", instr_valid, 0);
    tick();
    check("rq_discard_req", imem_req, 0);
    check("rq_discard_valid", instr_valid, 0);
    tick();
    check("rq_req2", imem_req, 1);
    check("rq_addr2", imem_addr, 32'h200);
    tick();
    tick();
    check("rq_head_pc", pc, 32'h200);
    check("rq_head_instr", instr, 32'h200 ^ K);

    // delayed grant holds the request; async reset mid-WAIT
    do_reset();
    id_ready = 1'b0;
    repeat (3) tick();
    imem_gnt = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("dg_req", imem_req, 1);
      check("dg_addr", imem_addr, 32'h4);
    end
    imem_gnt = 1'b1;
    auto_rsp = 1'b0;
    tick();
    check("dg_wait_req", imem_req, 0);
    check("dg_wait_valid", instr_valid, 1);
    rst_n = 1'b0;
    #2;
    check("ar_req", imem_req, 0);
    check("ar_addr", imem_addr, 32'h0);
    check("ar_valid", instr_valid, 0);
    check("ar_instr", instr, NOP);
    check("ar_pc", pc, 32'h0);
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    tick();
    rst_n = 1'b1;
    tick();
    check("late_valid", instr_valid, 0);
    check("late_req", imem_req, 1);
    check("late_addr", imem_addr, 32'h0);
    imem_rvalid = 1'b0;
    auto_rsp    = 1'b1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
